// File: rtl/jh_pkg.sv
// -----------------------------------------------------------------------------
// jh_pkg -- shared definitions for the JH round-constant generator.
//
// Contents:
//   JH_S0     : 4-bit S-box used on the constant path, entry i at [4i+3:4i]
//   JH_C0_D6  : first round constant C0 for the 64-nibble (D=6) configuration
//   m()       : doubling in GF(2^4) modulo x^4 + x + 1 (the JH "L" multiply)
//   state_t   : generator FSM state encoding
// -----------------------------------------------------------------------------
package jh_pkg;

   localparam logic [63:0]  JH_S0    = 64'hE85762A1F3CDB409;
   localparam logic [255:0] JH_C0_D6 =
      256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;

   // Shift left by one and fold the carried-out x^4 back in as x + 1.
   function automatic logic [3:0] m(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage : jh_pkg

// File: rtl/jh_rc_step.sv
// -----------------------------------------------------------------------------
// jh_rc_step -- one purely combinational round-constant update.
//
// rc_o = phi(P'(pi(L(S(rc_i))))) over N = 2^D nibbles, nibble i at [4i+3:4i].
//
// Parameters:
//   D      : log2 of the nibble count (N must be a multiple of 4, so D >= 2)
//   SBOX0  : 16-entry S-box, entry i at [4i+3:4i]
// Ports:
//   rc_i   : current round constant (W = 4*N bits)
//   rc_o   : next round constant
// -----------------------------------------------------------------------------
module jh_rc_step
   import jh_pkg::*;
#(
   parameter int          D     = 6,
   parameter logic [63:0] SBOX0 = JH_S0,
   localparam int         N     = 2 ** D,
   localparam int         W     = 4 * N
) (
   input  logic [W-1:0] rc_i,
   output logic [W-1:0] rc_o
);

   logic [3:0] sb    [N];
   logic [3:0] lin_a [N/2];
   logic [3:0] lin_b [N/2];
   logic [3:0] lin   [N];
   logic [3:0] pi_v  [N];
   logic [3:0] pp    [N];

   // S-box: the nibble value times four is the bit offset of its table entry.
   for (genvar g = 0; g < N; g++) begin : g_sbox
      assign sb[g] = SBOX0[{rc_i[4*g +: 4], 2'b00} +: 4];
   end

   // Linear layer per pair; a' uses the already-updated b'.
   for (genvar g = 0; g < N/2; g++) begin : g_lin
      assign lin_b[g]    = sb[2*g+1] ^ m(sb[2*g]);
      assign lin_a[g]    = sb[2*g] ^ m(lin_b[g]);
      assign lin[2*g]    = lin_a[g];
      assign lin[2*g+1]  = lin_b[g];
   end

   // pi: positions 4k+2 and 4k+3 trade places (index ^ 1 for the upper pair).
   for (genvar g = 0; g < N; g++) begin : g_pi
      localparam int SRC = ((g % 4) >= 2) ? (g ^ 1) : g;
      assign pi_v[g] = lin[SRC];
   end

   // P': even indices gather in the lower half, odd indices in the upper half.
   for (genvar g = 0; g < N/2; g++) begin : g_pprime
      assign pp[g]       = pi_v[2*g];
      assign pp[g + N/2] = pi_v[2*g+1];
   end

   // phi: adjacent pairs swap in the upper half only.
   for (genvar g = 0; g < N; g++) begin : g_phi
      localparam int SRC = (g < N/2) ? g : (g ^ 1);
      assign rc_o[4*g +: 4] = pp[SRC];
   end

endmodule : jh_rc_step

// File: rtl/jh_roundconst_gen.sv
// -----------------------------------------------------------------------------
// jh_roundconst_gen -- streams NUM_ROUNDS JH round constants C0, C1, ...
// over a valid/ready handshake, starting from INIT_RC.
//
// Parameters:
//   D, NUM_ROUNDS, SBOX0, INIT_RC (W = 4*2^D bits)
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a run (only looked at while idle)
//   abort     : (JH_RC_ABORT_EN only) drop the current run, no done pulse
//   rc_ready  : consumer accepts rc this cycle
//   rc        : current round constant, nibble i at [4i+3:4i]
//   rc_round  : index of rc within the run
//   rc_valid  : rc / rc_round are valid (equal to busy)
//   busy      : a run is in progress
//   done      : one-cycle pulse after the last constant is accepted
//
// Build option: define JH_RC_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module jh_roundconst_gen
   import jh_pkg::*;
#(
   parameter int                  D          = 6,
   parameter int                  NUM_ROUNDS = 42,
   parameter logic [63:0]         SBOX0      = JH_S0,
   parameter logic [4*(2**D)-1:0] INIT_RC    = JH_C0_D6,
   localparam int                 W          = 4 * (2 ** D),
   localparam int                 RW         = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
`ifdef JH_RC_ABORT_EN
   input  logic          abort,
`endif
   input  logic          rc_ready,
   output logic [W-1:0]  rc,
   output logic [RW-1:0] rc_round,
   output logic          rc_valid,
   output logic          busy,
   output logic          done
);

   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  rc_q, rc_d, rc_next;
   logic [RW-1:0] round_q, round_d;
   logic          done_q, done_d;
   logic          abort_req;
   logic          accept;

   jh_rc_step #(
      .D     (D),
      .SBOX0 (SBOX0)
   ) u_step (
      .rc_i (rc_q),
      .rc_o (rc_next)
   );

`ifdef JH_RC_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign accept = (state_q == ST_RUN) && rc_ready;

   always_comb begin
      // NOTE: every signal gets its hold/idle value first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      rc_d    = rc_q;
      round_d = round_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               rc_d    = INIT_RC;
               round_d = '0;
            end
         end
         ST_RUN: begin
            // Abort wins over a beat accepted in the same cycle.
            if (abort_req) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               if (round_q == LAST_ROUND) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  rc_d    = rc_next;
                  round_d = round_q + RW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every flop sampling the pre-edge
   // values; the rc register is reset too, since rc must read zero in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rc_q    <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   assign rc       = rc_q;
   assign rc_round = round_q;
   assign busy     = (state_q == ST_RUN);
   assign rc_valid = busy;
   assign done     = done_q;

endmodule : jh_roundconst_gen

// File: doc/jh_roundconst_gen.md
JH_ROUNDCONST_GEN -- requirements
Module: jh_roundconst_gen

Interface
REQ-001 SHALL have parameter D, default 6, meaning log2 of the nibble count; N = 2^D nibbles, RC width W = 4*N bits.
REQ-002 SHALL have parameter NUM_ROUNDS, default 42, meaning the number of round constants emitted per run.
REQ-003 SHALL have parameter SBOX0, default 64'hE85762A1F3CDB409, meaning the constant-path S-box, entry i at bits [4i+3:4i].
REQ-004 SHALL have parameter INIT_RC, default 256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a, meaning round constant C0, W bits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: begin a run (sampled in IDLE only).
REQ-008 SHALL have port rc, output, W bits: current round constant, nibble i at [4i+3:4i].
REQ-009 SHALL have port rc_round, output, $clog2(NUM_ROUNDS) bits: index of rc.
REQ-010 SHALL have port rc_valid, output, 1 bit: rc/rc_round are valid.
REQ-011 SHALL have port rc_ready, input, 1 bit: consumer accepts rc this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last constant is accepted.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; busy = (state==RUN); rc_valid = busy.
REQ-015 IDLE + start: next cycle state=RUN, rc=INIT_RC, rc_round=0 (rc_valid one cycle after start).
REQ-016 RUN, beat accepted (rc_valid&rc_ready), rc_round<NUM_ROUNDS-1: rc <= STEP(rc), rc_round increments.
REQ-017 RUN, beat accepted, rc_round==NUM_ROUNDS-1: state <= IDLE, done=1 for exactly the next cycle, rc holds last value.
REQ-018 RUN, rc_ready low: rc, rc_round, state hold indefinitely (no constant lost or skipped).
REQ-019 start while busy SHALL be ignored; start in the cycle done is high SHALL begin a new run.
REQ-020 STEP: per nibble S-box lookup t_i = SBOX0[rc_i].
REQ-021 STEP linear layer per pair (a=t_2k, b=t_2k+1): b' = b ^ m(a); a' = a ^ m(b'); m(x) = (x<<1)[3:0] ^ (x[3] ? 4'h3 : 0).
REQ-022 STEP permutation on N nibbles: pi swaps positions 4k+2/4k+3; P' sends even index 2i to i and odd 2i+1 to i+N/2; phi swaps pairs (2k,2k+1) within the upper half only.
REQ-023 With D=6, STEP SHALL be bit-exact with the existing 64-nibble JH round-constant update.
REQ-024 NUM_ROUNDS=1 SHALL emit only INIT_RC, then done.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, rc=0, rc_round=0, rc_valid=0, busy=0, done=0, including mid-run; no done pulse results.
REQ-026 After rst release, first start SHALL behave per REQ-015.

Configuration
REQ-027 Macro JH_RC_ABORT_EN defined: input port abort (1 bit); abort high in RUN returns to IDLE next cycle, rc_valid=0, no done pulse; abort has priority over an accepted beat; abort in IDLE is ignored.
REQ-028 Macro undefined: no abort port; a run ends only by completion or rst.

Structure
REQ-029 Shared package jh_pkg SHALL hold JH_S0 constant, JH_C0_D6 constant, m() function, and FSM state typedef.
REQ-030 STEP SHALL be a purely combinational sub-module jh_rc_step parameterised by D and SBOX0; the generator holds only the FSM, counter and rc register.

Verification
REQ-031 D=6 defaults, start pulse, rc_ready=1: 42 consecutive beats, rc_round 0..41, beat0 rc=INIT_RC, each beat = golden model STEP^k(C0), done pulses once one cycle after beat 41.
REQ-032 Random rc_ready (50%): accepted sequence identical to REQ-031; values held stable while ready low.
REQ-033 rst asserted at beat 20 while rc_ready low: outputs zero same cycle asynchronously; new start restarts at C0 with rc_round=0.
REQ-034 start pulsed at beats 5 and 30: ignored, sequence unchanged; start in done cycle: new run with C0 next cycle.
REQ-035 D=3 (N=8), NUM_ROUNDS=4, INIT_RC=32'h01234567: 4 beats matching golden model, done after 4th; NUM_ROUNDS=1: single beat then done.
REQ-036 JH_RC_ABORT_EN defined: abort at beat 10 coinciding with accept -> IDLE next cycle, rc_valid=0, no done pulse.
